seq_divider: RTL and testbench

- Parametrised iterative integer divider; next generation of the team's fixed 8-bit divider.
- Restoring algorithm, one quotient bit per clock.
- Start/busy/done handshake, runtime signed/unsigned select, divide-by-zero and overflow flags.
- Sits beside the ALU in the lab datapath; multi-cycle ops stall on busy.

---
 rtl/seq_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Restoring integer divider, one quotient bit per clock; done pulses WIDTH+2 cycles after start.
// Build option SEQ_DIVIDER_SIGNED_EN enables signed_mode and the overflow flag (else unsigned only).
module seq_divider #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_mag;
   logic [CNT_W-1:0] cnt;
   logic             dz_pend;

   logic             divisor_zero;
   logic [WIDTH-1:0] dvd_mag_in;
   logic [WIDTH-1:0] dvs_mag_in;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             accept;

   assign accept       = (state == IDLE) && start;
   assign divisor_zero = (divisor == '0);
   assign busy         = (state != IDLE);

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic             q_neg;
   logic             r_neg;
   logic             ov_pend;
   logic             dvd_is_neg;
   logic             dvs_is_neg;
   logic [WIDTH-1:0] dvd_negated;
   logic [WIDTH-1:0] dvs_negated;
   logic [WIDTH-1:0] quo_fixed;
   logic [WIDTH-1:0] rem_fixed;

   assign dvd_is_neg  = signed_mode && dividend[WIDTH-1];
   assign dvs_is_neg  = signed_mode && divisor[WIDTH-1];
   assign dvd_negated = -dividend;
   assign dvs_negated = -divisor;
   // MIN negates to itself, which is still the correct unsigned magnitude.
   assign dvd_mag_in  = dvd_is_neg ? dvd_negated : dividend;
   assign dvs_mag_in  = dvs_is_neg ? dvs_negated : divisor;
   assign quo_fixed   = q_neg ? -quo_r : quo_r;
   assign rem_fixed   = r_neg ? -rem_r : rem_r;
`else
   logic unused_signed_mode;

   assign unused_signed_mode = signed_mode;
   assign dvd_mag_in         = dividend;
   assign dvs_mag_in         = divisor;
   assign overflow           = 1'b0;
`endif

   // Trial subtraction at WIDTH+1 bits; bit WIDTH is the borrow.
   assign shifted = {rem_r, quo_r[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_mag};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = divisor_zero ? FIX : RUN;
            end
         end
         RUN: begin
            if (cnt == CNT_LAST) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_r       <= '0;
         quo_r       <= '0;
         dvs_mag     <= '0;
         cnt         <= '0;
         dz_pend     <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= (state == FIX);
         if (accept) begin
            rem_r       <= '0;
            // On divide-by-zero quo_r carries the raw dividend straight to remainder.
            quo_r       <= divisor_zero ? dividend : dvd_mag_in;
            dvs_mag     <= dvs_mag_in;
            cnt         <= CNT_INIT;
            dz_pend     <= divisor_zero;
            div_by_zero <= 1'b0;
         end else if (state == RUN) begin
            if (!diff[WIDTH]) begin
               rem_r <= diff[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
               rem_r <= shifted[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_LAST;
         end else if (state == FIX) begin
            if (dz_pend) begin
               quotient    <= '1;
               remainder   <= quo_r;
               div_by_zero <= 1'b1;
            end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
               quotient  <= quo_fixed;
               remainder <= rem_fixed;
`else
               quotient  <= quo_r;
               remainder <= rem_r;
`endif
            end
         end
      end
   end

`ifdef SEQ_DIVIDER_SIGNED_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         ov_pend  <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         q_neg    <= dvd_is_neg ^ dvs_is_neg;
         r_neg    <= dvd_is_neg;
         ov_pend  <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
         overflow <= 1'b0;
      end else if (state == FIX) begin
         overflow <= ov_pend && !dz_pend;
      end
   end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: an 8-bit instance for arithmetic/flags/reset, a 16-bit one for throughput.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start8, sm8, busy8, done8, dz8, ov8;
   logic [7:0]  dvd8, dvs8, q8, r8;
   logic        start16, sm16, busy16, done16, dz16, ov16;
   logic [15:0] dvd16, dvs16, q16, r16;

   int passed = 0;
   int total  = 0;

`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [7:0] S1_Q = 8'hF2, S1_R = 8'hFE;
   localparam logic [7:0] S2_Q = 8'hF2, S2_R = 8'h02;
   localparam logic [7:0] OV_Q = 8'h80, OV_R = 8'h00;
   localparam logic       OV_F = 1'b1;
`else
   localparam logic [7:0] S1_Q = 8'h16, S1_R = 8'h02;
   localparam logic [7:0] S2_Q = 8'h00, S2_R = 8'h64;
   localparam logic [7:0] OV_Q = 8'h00, OV_R = 8'h80;
   localparam logic       OV_F = 1'b0;
`endif

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
   );

   seq_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
      .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
      .quotient(q16), .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
   );

   // Issues one 8-bit op; lat is the cycle (1 = first after the accepting edge) done is seen, -1 on timeout.
   task automatic run_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bc);
      @(negedge clk);
      sm8 = sgn; dvd8 = a; dvs8 = b; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      lat = -1;
      bc  = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy8) bc++;
         if (done8) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b0; sm8 = 1'b0; dvd8 = '0; dvs8 = '0;
      start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8); else passed++;
      total++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b want 0", done8); else passed++;
      total++; if ({q8, r8} !== 16'h0) $display("FAIL reset_qr: got %h want 0000", {q8, r8}); else passed++;
      total++; if ({dz8, ov8} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {dz8, ov8}); else passed++;
      total++; if ({busy16, done16, q16, r16} !== 34'h0) $display("FAIL reset_16: got %h want 0", {busy16, done16, q16, r16}); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned();
      int lat, bc;
      run_op8(1'b0, 8'd200, 8'd7, lat, bc);
      total++; if (lat !== 10) $display("FAIL u_latency: got %0d want 10", lat); else passed++;
      total++; if (bc !== 9) $display("FAIL u_busy_cycles: got %0d want 9", bc); else passed++;
      total++; if (q8 !== 8'h1C) $display("FAIL u_quotient: got %h want 1c", q8); else passed++;
      total++; if (r8 !== 8'h04) $display("FAIL u_remainder: got %h want 04", r8); else passed++;
      total++; if ({dz8, ov8} !== 2'b00) $display("FAIL u_flags: got %b want 00", {dz8, ov8}); else passed++;
      @(negedge clk);
      total++; if (done8 !== 1'b0) $display("FAIL u_done_pulse: got %b want 0", done8); else passed++;
      total++; if (q8 !== 8'h1C) $display("FAIL u_hold: got %h want 1c", q8); else passed++;
   endtask

   task automatic test_signed();
      int lat, bc;
      run_op8(1'b1, 8'h9C, 8'h07, lat, bc);
      total++; if (lat !== 10) $display("FAIL s1_latency: got %0d want 10", lat); else passed++;
      total++; if ({q8, r8} !== {S1_Q, S1_R}) $display("FAIL s1_qr: got %h want %h", {q8, r8}, {S1_Q, S1_R}); else passed++;
      total++; if ({dz8, ov8} !== 2'b00) $display("FAIL s1_flags: got %b want 00", {dz8, ov8}); else passed++;
      run_op8(1'b1, 8'd100, 8'hF9, lat, bc);
      total++; if ({q8, r8} !== {S2_Q, S2_R}) $display("FAIL s2_qr: got %h want %h", {q8, r8}, {S2_Q, S2_R}); else passed++;
      total++; if ({dz8, ov8} !== 2'b00) $display("FAIL s2_flags: got %b want 00", {dz8, ov8}); else passed++;
   endtask

   task automatic test_div_by_zero();
      int lat, bc;
      run_op8(1'b0, 8'd55, 8'd0, lat, bc);
      total++; if (lat !== 2) $display("FAIL dz_latency: got %0d want 2", lat); else passed++;
      total++; if ({q8, r8} !== 16'hFF37) $display("FAIL dz_qr: got %h want ff37", {q8, r8}); else passed++;
      total++; if (dz8 !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz8); else passed++;
      run_op8(1'b0, 8'd9, 8'd3, lat, bc);
      total++; if (lat !== 10) $display("FAIL dz_next_latency: got %0d want 10", lat); else passed++;
      total++; if ({q8, r8} !== 16'h0300) $display("FAIL dz_next_qr: got %h want 0300", {q8, r8}); else passed++;
      total++; if (dz8 !== 1'b0) $display("FAIL dz_next_flag: got %b want 0", dz8); else passed++;
   endtask

   task automatic test_overflow();
      int lat, bc;
      run_op8(1'b1, 8'h80, 8'hFF, lat, bc);
      total++; if (lat !== 10) $display("FAIL ov_latency: got %0d want 10", lat); else passed++;
      total++; if ({q8, r8} !== {OV_Q, OV_R}) $display("FAIL ov_qr: got %h want %h", {q8, r8}, {OV_Q, OV_R}); else passed++;
      total++; if (ov8 !== OV_F) $display("FAIL ov_flag: got %b want %b", ov8, OV_F); else passed++;
      total++; if (dz8 !== 1'b0) $display("FAIL ov_dz: got %b want 0", dz8); else passed++;
   endtask

   task automatic test_reset_abort();
      int lat, bc;
      bit seen;
      @(negedge clk);
      sm8 = 1'b0; dvd8 = 8'd200; dvs8 = 8'd7; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if ({busy8, done8} !== 2'b00) $display("FAIL abort_ctrl: got %b want 00", {busy8, done8}); else passed++;
      total++; if ({q8, r8} !== 16'h0) $display("FAIL abort_qr: got %h want 0000", {q8, r8}); else passed++;
      total++; if ({dz8, ov8} !== 2'b00) $display("FAIL abort_flags: got %b want 00", {dz8, ov8}); else passed++;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done8 || busy8) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen); else passed++;
      run_op8(1'b0, 8'd200, 8'd7, lat, bc);
      total++; if (lat !== 10) $display("FAIL abort_rerun_latency: got %0d want 10", lat); else passed++;
      total++; if ({q8, r8} !== 16'h1C04) $display("FAIL abort_rerun_qr: got %h want 1c04", {q8, r8}); else passed++;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, bc1, bc2;
      @(negedge clk);
      sm16 = 1'b0; dvd16 = 16'd60000; dvs16 = 16'd123; start16 = 1'b1;
      @(posedge clk);
      lat1 = -1; bc1 = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 3) begin dvd16 = 16'd5; dvs16 = 16'd1; end
         if (i == 10) begin dvd16 = 16'd60000; dvs16 = 16'd123; end
         if (busy16) bc1++;
         if (done16) begin lat1 = i; break; end
      end
      total++; if (lat1 !== 18) $display("FAIL b2b_latency1: got %0d want 18", lat1); else passed++;
      total++; if (bc1 !== 17) $display("FAIL b2b_busy1: got %0d want 17", bc1); else passed++;
      total++; if ({q16, r16} !== {16'd487, 16'd99}) $display("FAIL b2b_qr1: got %0d/%0d want 487/99", q16, r16); else passed++;
      lat2 = -1; bc2 = 0;
      for (int j = 1; j <= 60; j++) begin
         @(negedge clk);
         if (busy16) bc2++;
         if (done16) begin lat2 = j; break; end
      end
      start16 = 1'b0;
      total++; if (lat2 !== 18) $display("FAIL b2b_latency2: got %0d want 18", lat2); else passed++;
      total++; if (bc2 !== 17) $display("FAIL b2b_busy2: got %0d want 17", bc2); else passed++;
      total++; if ({q16, r16} !== {16'd487, 16'd99}) $display("FAIL b2b_qr2: got %0d/%0d want 487/99", q16, r16); else passed++;
      total++; if ({dz16, ov16} !== 2'b00) $display("FAIL b2b_flags: got %b want 00", {dz16, ov16}); else passed++;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_overflow();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
